// File: rtl/ysyx_24080006_axi_sram_if.sv
// Single-beat AXI4 bus between the LSU (master) and the SRAM responder (slave).
// A transfer completes on the rising clock edge at which both valid and ready are 1. Once the source raises
// valid, it holds valid and its payload stable until that edge. Ready may rise and fall freely.
interface ysyx_24080006_axi_sram_if;
   logic        arvalid;
   logic [31:0] araddr;
   logic [2:0]  arsize;
   logic [7:0]  arlen;
   logic [1:0]  arburst;
   logic        arready;

   logic        rvalid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rready;

   logic        awvalid;
   logic [31:0] awaddr;
   logic [2:0]  awsize;
   logic [7:0]  awlen;
   logic [1:0]  awburst;
   logic        awready;

   logic        wvalid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wready;

   logic        bvalid;
   logic [1:0]  bresp;
   logic        bready;

   // Current read/write FSM state, exported for checkers.
   logic [1:0]  rd_state_dbg;
   logic [1:0]  wr_state_dbg;

   modport slave (
      input  arvalid, araddr, arsize, arlen, arburst, rready,
      input  awvalid, awaddr, awsize, awlen, awburst,
      input  wvalid, wdata, wstrb, wlast, bready,
      output arready, rvalid, rdata, rresp, rlast,
      output awready, wready, bvalid, bresp,
      output rd_state_dbg, wr_state_dbg
   );

   modport master (
      output arvalid, araddr, arsize, arlen, arburst, rready,
      output awvalid, awaddr, awsize, awlen, awburst,
      output wvalid, wdata, wstrb, wlast, bready,
      input  arready, rvalid, rdata, rresp, rlast,
      input  awready, wready, bvalid, bresp,
      input  rd_state_dbg, wr_state_dbg
   );
endinterface

// File: rtl/ysyx_24080006_axi_sram.sv
// Single-beat AXI4 SRAM responder with one outstanding read and one outstanding write.
// Response latencies are fixed by RD_LAT and WR_LAT. A read that coincides with a write to the same word sees the new data.
module ysyx_24080006_axi_sram #(
   parameter int unsigned ADDR_W = 12,
   parameter logic [31:0] BASE   = 32'h8000_0000,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned WR_LAT = 1
) (
   input logic                     clock,
   input logic                     reset,
   ysyx_24080006_axi_sram_if.slave bus
);
   localparam int unsigned DEPTH       = 1 << ADDR_W;
   localparam logic [32:0] LIMIT       = {1'b0, BASE} + (33'(DEPTH) << 2);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [3:0]  RD_CNT_INIT = 4'(RD_LAT - 1);
   localparam logic [3:0]  WR_CNT_INIT = 4'(WR_LAT - 1);

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

   function automatic logic req_err(input logic [31:0] addr, input logic [2:0] size,
                                    input logic [7:0] len);
      logic bad_range;
      logic bad_align;
      bad_range = ({1'b0, addr} < {1'b0, BASE}) || ({1'b0, addr} >= LIMIT);
      bad_align = ((size == 3'd1) && addr[0]) || ((size == 3'd2) && (addr[1:0] != 2'b00));
      return bad_range || (len != 8'd0) || (size > 3'd2) || bad_align;
   endfunction

   logic [31:0] mem [DEPTH];

   // ---------------- read channel state ----------------
   rd_state_t   rd_state;
   logic [3:0]  rd_cnt;
   logic [31:0] ar_addr_q;
   logic [2:0]  ar_size_q;
   logic [7:0]  ar_len_q;
   logic        arready_q;
   logic        rvalid_q;
   logic [31:0] rdata_q;
   logic [1:0]  rresp_q;

   logic              ar_fire;
   logic              r_fire;
   logic              rd_sample;
   logic [31:0]       rd_addr_eff;
   logic [2:0]        rd_size_eff;
   logic [7:0]        rd_len_eff;
   logic              rd_err;
   logic [ADDR_W-1:0] rd_idx;
   logic [31:0]       rd_word;

   // ---------------- write channel state ----------------
   wr_state_t   wr_state;
   logic [3:0]  wr_cnt;
   logic [31:0] aw_addr_q;
   logic [2:0]  aw_size_q;
   logic [7:0]  aw_len_q;
   logic [31:0] w_data_q;
   logic [3:0]  w_strb_q;
   logic        aw_have;
   logic        w_have;
   logic        awready_q;
   logic        wready_q;
   logic        bvalid_q;
   logic [1:0]  bresp_q;

   logic              aw_fire;
   logic              w_fire;
   logic              b_fire;
   logic              aw_have_n;
   logic              w_have_n;
   logic [31:0]       wr_addr_eff;
   logic [2:0]        wr_size_eff;
   logic [7:0]        wr_len_eff;
   logic [31:0]       wr_data_eff;
   logic [3:0]        wr_strb_eff;
   logic              wr_commit_evt;
   logic              wr_err;
   logic              wr_commit;
   logic [ADDR_W-1:0] wr_idx;

   logic unused_bits;
   assign unused_bits = ^{bus.arburst, bus.awburst, bus.wlast};

   assign ar_fire = bus.arvalid & arready_q;
   assign r_fire  = rvalid_q & bus.rready;
   assign aw_fire = bus.awvalid & awready_q;
   assign w_fire  = bus.wvalid & wready_q;
   assign b_fire  = bvalid_q & bus.bready;

   // With RD_LAT==1 the array is sampled on the AR handshake edge itself, so use the live bus request.
   always_comb begin
      rd_addr_eff = ar_addr_q;
      rd_size_eff = ar_size_q;
      rd_len_eff  = ar_len_q;
      rd_sample   = 1'b0;
      if (rd_state == R_IDLE) begin
         rd_addr_eff = bus.araddr;
         rd_size_eff = bus.arsize;
         rd_len_eff  = bus.arlen;
         rd_sample   = ar_fire && (RD_LAT == 1);
      end else if (rd_state == R_WAIT) begin
         rd_sample   = (rd_cnt == 4'd1);
      end
   end

   assign rd_idx = rd_addr_eff[ADDR_W+1:2];
   assign rd_err = req_err(rd_addr_eff, rd_size_eff, rd_len_eff);

   // A payload handshaking this cycle takes precedence over the (still empty) holding register.
   always_comb begin
      aw_have_n   = aw_have | aw_fire;
      w_have_n    = w_have | w_fire;
      wr_addr_eff = aw_fire ? bus.awaddr : aw_addr_q;
      wr_size_eff = aw_fire ? bus.awsize : aw_size_q;
      wr_len_eff  = aw_fire ? bus.awlen  : aw_len_q;
      wr_data_eff = w_fire  ? bus.wdata  : w_data_q;
      wr_strb_eff = w_fire  ? bus.wstrb  : w_strb_q;
      wr_commit_evt = 1'b0;
      if (wr_state == W_IDLE)
         wr_commit_evt = aw_have_n && w_have_n && (WR_LAT == 1);
      else if (wr_state == W_WAIT)
         wr_commit_evt = (wr_cnt == 4'd1);
   end

   assign wr_err    = req_err(wr_addr_eff, wr_size_eff, wr_len_eff);
   assign wr_commit = wr_commit_evt && !wr_err;
   assign wr_idx    = wr_addr_eff[ADDR_W+1:2];

   // Write-first: a commit landing on the word being sampled is merged byte by byte.
   always_comb begin
      rd_word = mem[rd_idx];
      if (wr_commit && (wr_idx == rd_idx)) begin
         for (int i = 0; i < 4; i++)
            if (wr_strb_eff[i]) rd_word[8*i +: 8] = wr_data_eff[8*i +: 8];
      end
   end

   always_ff @(posedge clock) begin
      if (reset && wr_commit) begin
         for (int i = 0; i < 4; i++)
            if (wr_strb_eff[i]) mem[wr_idx][8*i +: 8] <= wr_data_eff[8*i +: 8];
      end
   end

   // ---------------- read FSM ----------------
   always_ff @(posedge clock) begin
      if (!reset) begin
         rd_state  <= R_IDLE;
         rd_cnt    <= 4'd0;
         ar_addr_q <= 32'd0;
         ar_size_q <= 3'd0;
         ar_len_q  <= 8'd0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= 32'd0;
         rresp_q   <= RESP_OKAY;
      end else begin
         case (rd_state)
            R_IDLE: begin
               arready_q <= 1'b1;
               if (ar_fire) begin
                  ar_addr_q <= bus.araddr;
                  ar_size_q <= bus.arsize;
                  ar_len_q  <= bus.arlen;
                  arready_q <= 1'b0;
                  rd_cnt    <= RD_CNT_INIT;
                  rd_state  <= R_WAIT;
               end
            end
            R_WAIT: rd_cnt <= rd_cnt - 4'd1;
            R_RESP: begin
               if (r_fire) begin
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
                  rd_state  <= R_IDLE;
               end
            end
            default: rd_state <= R_IDLE;
         endcase
         if (rd_sample) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_err ? 32'd0 : rd_word;
            rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            rd_state <= R_RESP;
         end
      end
   end

   // ---------------- write FSM ----------------
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_state  <= W_IDLE;
         wr_cnt    <= 4'd0;
         aw_addr_q <= 32'd0;
         aw_size_q <= 3'd0;
         aw_len_q  <= 8'd0;
         w_data_q  <= 32'd0;
         w_strb_q  <= 4'd0;
         aw_have   <= 1'b0;
         w_have    <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         case (wr_state)
            W_IDLE: begin
               if (aw_fire) begin
                  aw_addr_q <= bus.awaddr;
                  aw_size_q <= bus.awsize;
                  aw_len_q  <= bus.awlen;
               end
               if (w_fire) begin
                  w_data_q <= bus.wdata;
                  w_strb_q <= bus.wstrb;
               end
               aw_have   <= aw_have_n;
               w_have    <= w_have_n;
               awready_q <= !aw_have_n;
               wready_q  <= !w_have_n;
               if (aw_have_n && w_have_n) begin
                  wr_cnt   <= WR_CNT_INIT;
                  wr_state <= W_WAIT;
               end
            end
            W_WAIT: wr_cnt <= wr_cnt - 4'd1;
            W_RESP: begin
               if (b_fire) begin
                  bvalid_q  <= 1'b0;
                  aw_have   <= 1'b0;
                  w_have    <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
                  wr_state  <= W_IDLE;
               end
            end
            default: wr_state <= W_IDLE;
         endcase
         if (wr_commit_evt) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            wr_state <= W_RESP;
         end
      end
   end

   assign bus.arready      = arready_q;
   assign bus.rvalid       = rvalid_q;
   assign bus.rdata        = rdata_q;
   assign bus.rresp        = rresp_q;
   assign bus.rlast        = rvalid_q;
   assign bus.awready      = awready_q;
   assign bus.wready       = wready_q;
   assign bus.bvalid       = bvalid_q;
   assign bus.bresp        = bresp_q;
   assign bus.rd_state_dbg = rd_state;
   assign bus.wr_state_dbg = wr_state;
endmodule

// File: doc/ysyx_24080006_axi_sram.md
Name: ysyx_24080006_axi_sram

Overview:
AXI4 single-beat memory responder (subordinate) backed by a word-organised RAM array. It answers the LSU's AR/R and AW/W/B channels: one outstanding read and one outstanding write, with fixed, parameterised response latencies. Serves as the data-memory model on the LSU's AXI bus and as a latency-configurable target for pipeline verification.

Parameters:
ADDR_W, 12, word-index bits; array holds 2**ADDR_W 32-bit words.
BASE, 32'h8000_0000, byte base address; in range = BASE <= addr < BASE + 4*2**ADDR_W.
RD_LAT, 1, cycles from AR handshake to first rvalid; legal 1..15.
WR_LAT, 1, cycles from the later of the AW/W handshakes to first bvalid; legal 1..15.

Ports:
clock  in  1  sole clock, rising edge.
reset  in  1  synchronous, active-low (0 = reset).
arvalid in 1; araddr in 32; arsize in 3; arlen in 8; arburst in 2  AR channel from master.
arready  out  1  AR accept.
rvalid out 1; rdata out 32; rresp out 2; rlast out 1  R channel.
rready  in  1  R accept.
awvalid in 1; awaddr in 32; awsize in 3; awlen in 8; awburst in 2  AW channel.
awready  out  1  AW accept.
wvalid in 1; wdata in 32; wstrb in 4; wlast in 1  W channel (data already lane-aligned by master).
wready  out  1  W accept.
bvalid out 1; bresp out 2  B channel.
bready  in  1  B accept.

Behaviour:
- Reset (reset==0 at a clock edge): all outputs 0 (arready, awready, wready, rvalid, bvalid, rdata, rresp, rlast, bresp); both FSMs to idle; latency counters 0. RAM contents not reset. Reset mid-transaction discards the transaction; no response is issued.
- All outputs registered. Ready signals rise in the first cycle after reset release.
- Read FSM, states R_IDLE -> R_WAIT -> R_RESP -> R_IDLE:
  - R_IDLE: arready=1. On arvalid&arready: latch araddr/arsize/arlen, arready<=0, counter<=RD_LAT-1. Go to R_RESP directly if RD_LAT==1, else R_WAIT.
  - R_WAIT: decrement counter; at 0 go to R_RESP.
  - Handshake at cycle T: rvalid first high at T+RD_LAT. rdata = full 32-bit word at araddr[ADDR_W+1:2]; no shifting (master extracts the lane). rlast=1 whenever rvalid.
  - R_RESP: rvalid, rdata, rresp held stable until rvalid&rready; then rvalid<=0, arready<=1, back to R_IDLE. Master raising rready several cycles late is legal.
- Write FSM, states W_IDLE -> W_WAIT -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1, wready=1. AW and W are accepted independently, in either order or the same cycle. Each ready drops the cycle after its own handshake and the payload is latched. Once both are held, counter<=WR_LAT-1 and go to W_WAIT.
  - W_WAIT: decrement counter; at 0 commit the write (byte lanes where wstrb[i]=1) and go to W_RESP with bvalid<=1.
  - Later of the two handshakes at cycle T: commit at T+WR_LAT-1, bvalid at T+WR_LAT.
  - W_RESP: bvalid and bresp held until bvalid&bready; then awready<=1, wready<=1, back to W_IDLE.
- Error rule, evaluated on the latched request; resp = 2'b10 SLVERR, else 2'b00 OKAY:
  - address out of range;
  - arlen/awlen != 0;
  - arsize/awsize > 2;
  - misaligned: size 1 with addr[0]=1, or size 2 with addr[1:0]!=0.
  - On read error, rdata = 0. On write error, no RAM update.
  - burst, wlast and the unused high byte lanes are ignored; wstrb=0 is a legal no-op returning OKAY.
- Collision: if a read samples the RAM in the same cycle that a write commits to the same word, the read returns post-write data (write-first, byte-merged).
- Read and write channels otherwise operate concurrently and independently.

Test Plan:
- Reset hold 3 cycles then release -> all outputs 0 during reset; arready/awready/wready = 1 in the first cycle after release; rvalid/bvalid stay 0.
- Word write: AW 0x8000_0010 (size 2) and W 0xDEAD_BEEF/strb 4'b1111 in the same cycle T, RD_LAT=WR_LAT=1 -> bvalid at T+1 with OKAY. Then read 0x8000_0010 -> rdata 0xDEAD_BEEF at AR handshake +1, rresp OKAY, rlast 1.
- Byte write: wdata 0x00AB_0000, strb 4'b0100 to 0x8000_0012 over word 0x1122_3344 -> read returns 0x11AB_3344. W accepted 2 cycles before AW -> bvalid exactly WR_LAT after the AW handshake.
- Backpressure with RD_LAT=3: AR handshake at T, rready held low 4 cycles -> rvalid rises at T+3; rdata/rresp stable until rready; arready stays 0 until the cycle after the R handshake.
- Errors: read 0x7FFF_FFFC -> SLVERR, rdata 0. Halfword write at 0x8000_0003 -> SLVERR, RAM unchanged. arlen=1 -> SLVERR.
- Collision and reset: a write committing to word W in the same cycle a read of W samples -> read returns new data. reset=0 asserted while in R_WAIT -> no rvalid ever; idle with arready=1 after release.
